// File: rtl/shift_unstreamer_if.sv
// Handshake bundle for shift_unstreamer.
//   Input stream  : data_i, last_i, vld_i -> rdy_o
//   Output window : data_o, avail_o, last_o, vld_o <- shift_i, rdy_i
// Signal names are written from the unpacker's point of view.
// slave  = unpacker side, master = producer/consumer side.
interface shift_unstreamer_if #(
    parameter int DATA_W = 8
);
    localparam int AW = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] data_i;
    logic              last_i;
    logic              vld_i;
    logic              rdy_o;
    logic [DATA_W-1:0] data_o;
    logic [AW-1:0]     avail_o;
    logic              last_o;
    logic              vld_o;
    logic [AW-1:0]     shift_i;
    logic              rdy_i;

    modport slave (
        input  data_i, last_i, vld_i, shift_i, rdy_i,
        output rdy_o, data_o, avail_o, last_o, vld_o
    );

    modport master (
        output data_i, last_i, vld_i, shift_i, rdy_i,
        input  rdy_o, data_o, avail_o, last_o, vld_o
    );
endinterface

// File: rtl/shift_unstreamer.sv
// shift_unstreamer: decoder-side bit unpacker. Packed DATA_W-bit words come in on
// the input stream. A DATA_W-bit MSB-aligned look-ahead window is presented to a
// variable-length symbol decoder, which consumes 0..DATA_W bits per handshake.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   bus (slave)   : input stream data_i/last_i/vld_i/rdy_o,
//                   window data_o/avail_o/last_o/vld_o, consume shift_i/rdy_i
//   flush_i       : drop all buffered bits and the last flag
//   idle_o        : buffer empty, no block in progress
//   err_o         : sticky over-consumption flag
// Optional macro SHIFT_UNSTREAMER_ERR_EN enables the err_o checker. Without it,
// err_o is tied low. Over-consumption always saturates to the buffered fill.
module shift_unstreamer #(
    parameter int DATA_W = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    shift_unstreamer_if.slave     bus,
    input  logic                  flush_i,
    output logic                  idle_o,
    output logic                  err_o
);
    localparam int AW = $clog2(DATA_W + 1);
    localparam int BW = 2 * DATA_W;
    localparam int FW = $clog2(BW + 1);

    typedef enum logic [1:0] {EMPTY, FILLING, AVAIL, DRAIN} st_e;

    st_e           st_q, st_d;
    logic [BW-1:0] buf_q, buf_d;
    logic [FW-1:0] fill_q, fill_d;
    logic          last_q, last_d;

    logic          vld, rdy, hs_out, hs_in;
    logic [FW-1:0] shift_ext, cons, tail;

    // Outputs depend on registered state only.
    assign vld         = (st_q == AVAIL) || (st_q == DRAIN);
    assign rdy         = (fill_q <= FW'(DATA_W)) && !last_q;
    assign bus.vld_o   = vld;
    assign bus.rdy_o   = rdy;
    assign bus.data_o  = buf_q[BW-1 -: DATA_W];
    assign bus.avail_o = (fill_q >= FW'(DATA_W)) ? AW'(DATA_W) : fill_q[AW-1:0];
    assign bus.last_o  = last_q && (fill_q <= FW'(DATA_W)) && vld;
    assign idle_o      = (st_q == EMPTY);

    assign hs_out    = vld && bus.rdy_i;
    assign hs_in     = bus.vld_i && rdy;
    assign shift_ext = FW'(bus.shift_i);
    // Saturate consumption to the bits actually held.
    assign cons      = hs_out ? ((shift_ext > fill_q) ? fill_q : shift_ext) : '0;
    // Post-consume tail position. It is <= DATA_W whenever rdy is high, so an
    // accepted word always fits.
    assign tail      = fill_q - cons;

    always_comb begin
        buf_d  = buf_q << cons;
        fill_d = tail;
        last_d = last_q;
        st_d   = st_q;
        if (hs_in) begin
            buf_d  = buf_d | ({bus.data_i, {DATA_W{1'b0}}} >> tail);
            fill_d = tail + FW'(DATA_W);
            last_d = bus.last_i;
        end
        if (fill_d == '0) begin
            last_d = 1'b0;
            st_d   = EMPTY;
        end else if (fill_d >= FW'(DATA_W)) begin
            st_d   = AVAIL;
        end else if (last_d) begin
            st_d   = DRAIN;
        end else begin
            st_d   = FILLING;
        end
        if (flush_i) begin
            buf_d  = '0;
            fill_d = '0;
            last_d = 1'b0;
            st_d   = EMPTY;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_q   <= EMPTY;
            buf_q  <= '0;
            fill_q <= '0;
            last_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            buf_q  <= buf_d;
            fill_q <= fill_d;
            last_q <= last_d;
        end
    end

`ifdef SHIFT_UNSTREAMER_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (hs_out && ((shift_ext > fill_q) || (bus.shift_i > AW'(DATA_W))))
            err_d = 1'b1;
        if (flush_i)
            err_d = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) err_q <= 1'b0;
        else         err_q <= err_d;
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

`ifndef SYNTHESIS
    a_shift_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        hs_out |-> (bus.shift_i <= AW'(DATA_W)));
    a_tail_zero: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (buf_q << fill_q) == '0);
    a_fill_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        fill_q <= FW'(BW));
`endif
endmodule

// File: tb/tb_shift_unstreamer.sv
module tb_shift_unstreamer;
    localparam int DATA_W = 8;
`ifdef SHIFT_UNSTREAMER_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic idle, err;
    int   checks = 0;
    int   errors = 0;

    shift_unstreamer_if #(.DATA_W(DATA_W)) bus ();

    shift_unstreamer #(.DATA_W(DATA_W)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus),
        .flush_i(flush),
        .idle_o (idle),
        .err_o  (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       fl, vi;
        logic [7:0] din;
        logic       li, ri;
        logic [3:0] sh;
        logic [7:0] e_data;
        logic [3:0] e_avail;
        logic       e_vld, e_rdy, e_last, e_idle;
    } vec_t;

    vec_t vt[15];

    function automatic vec_t mk(logic fl, logic vi, logic [7:0] din, logic li, logic ri,
                                logic [3:0] sh, logic [7:0] ed, logic [3:0] ea,
                                logic ev, logic er, logic el, logic ei);
        vec_t v;
        v.fl = fl; v.vi = vi; v.din = din; v.li = li; v.ri = ri; v.sh = sh;
        v.e_data = ed; v.e_avail = ea; v.e_vld = ev; v.e_rdy = er; v.e_last = el; v.e_idle = ei;
        return v;
    endfunction

    task automatic chk(string nm, int idx, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got 0x%0h expected 0x%0h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(logic fl, logic vi, logic [7:0] din, logic li, logic ri, logic [3:0] sh);
        flush = fl; bus.vld_i = vi; bus.data_i = din; bus.last_i = li;
        bus.rdy_i = ri; bus.shift_i = sh;
    endtask

    // One clock with the given inputs; outputs are sampled 1 time unit after the edge.
    task automatic step(logic fl, logic vi, logic [7:0] din, logic li, logic ri, logic [3:0] sh);
        drive(fl, vi, din, li, ri, sh);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic chk_out(int idx, logic [7:0] ed, logic [3:0] ea, logic ev, logic er,
                           logic el, logic ei, logic ee);
        chk("data_o",  idx, bus.data_o, ed);
        chk("avail_o", idx, {4'h0, bus.avail_o}, {4'h0, ea});
        chk("vld_o",   idx, {7'h0, bus.vld_o}, {7'h0, ev});
        chk("rdy_o",   idx, {7'h0, bus.rdy_o}, {7'h0, er});
        chk("last_o",  idx, {7'h0, bus.last_o}, {7'h0, el});
        chk("idle_o",  idx, {7'h0, idle}, {7'h0, ei});
        chk("err_o",   idx, {7'h0, err}, {7'h0, ee});
    endtask

    initial begin
        //          fl vi din    li ri sh    data  av vld rdy lst idl
        vt[0]  = mk(0, 1, 8'hA5, 0, 0, 4'd0, 8'hA5, 8, 1, 1, 0, 0); // first word
        vt[1]  = mk(0, 1, 8'h3C, 0, 0, 4'd0, 8'hA5, 8, 1, 0, 0, 0); // fill 16
        vt[2]  = mk(0, 0, 8'h00, 0, 1, 4'd3, 8'h29, 8, 1, 0, 0, 0); // fill 13
        vt[3]  = mk(1, 1, 8'h55, 0, 0, 4'd0, 8'h00, 0, 0, 1, 0, 1); // flush drops word
        vt[4]  = mk(0, 1, 8'hF0, 1, 0, 4'd0, 8'hF0, 8, 1, 0, 1, 0); // last word, AVAIL
        vt[5]  = mk(0, 0, 8'h00, 0, 1, 4'd4, 8'h00, 4, 1, 0, 1, 0); // DRAIN
        vt[6]  = mk(0, 0, 8'h00, 0, 1, 4'd4, 8'h00, 0, 0, 1, 0, 1); // EMPTY
        vt[7]  = mk(0, 1, 8'hA5, 0, 0, 4'd0, 8'hA5, 8, 1, 1, 0, 0);
        vt[8]  = mk(0, 1, 8'hFF, 0, 1, 4'd5, 8'hBF, 8, 1, 0, 0, 0); // consume+accept, fill 11
        vt[9]  = mk(0, 0, 8'h00, 0, 1, 4'd0, 8'hBF, 8, 1, 0, 0, 0); // shift 0 no-op
        vt[10] = mk(0, 0, 8'h00, 0, 1, 4'd8, 8'hE0, 3, 0, 1, 0, 0); // FILLING, fill 3
        vt[11] = mk(0, 1, 8'h12, 1, 0, 4'd0, 8'hE2, 8, 1, 0, 0, 0); // last, fill 11
        vt[12] = mk(0, 0, 8'h00, 0, 1, 4'd8, 8'h40, 3, 1, 0, 1, 0); // DRAIN fill 3
        vt[13] = mk(0, 0, 8'h00, 0, 1, 4'd3, 8'h00, 0, 0, 1, 0, 1); // drained
        vt[14] = mk(0, 0, 8'h00, 0, 1, 4'd5, 8'h00, 0, 0, 1, 0, 1); // rdy_i with no window

        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0);
        repeat (2) @(posedge clk);
        #1;
        chk_out(100, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0); // in reset
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_out(101, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 15; i++) begin
            step(vt[i].fl, vt[i].vi, vt[i].din, vt[i].li, vt[i].ri, vt[i].sh);
            chk_out(i, vt[i].e_data, vt[i].e_avail, vt[i].e_vld, vt[i].e_rdy,
                    vt[i].e_last, vt[i].e_idle, 1'b0);
        end

        // Over-consumption: 4 bits left in DRAIN, decoder asks for 6.
        step(1'b0, 1'b1, 8'hF0, 1'b1, 1'b0, 4'd0);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 4'd4);
        chk_out(200, 8'h00, 4'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 4'd6);
        chk_out(201, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, ERR_EXP);
        step(1'b0, 1'b1, 8'h81, 1'b0, 1'b0, 4'd0);          // sticky across new data
        chk_out(202, 8'h81, 4'd8, 1'b1, 1'b1, 1'b0, 1'b0, ERR_EXP);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0);          // flush clears err
        chk_out(203, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset mid-block drops bits without waiting for a clock edge.
        step(1'b0, 1'b1, 8'hC3, 1'b0, 1'b0, 4'd0);
        step(1'b0, 1'b1, 8'h7E, 1'b0, 1'b0, 4'd0);
        chk_out(300, 8'hC3, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_out(301, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 4'd0);
        chk_out(302, 8'h3C, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
